video_blend: RTL and testbench
==============================

Name: video_blend

Overview:
- Post-palette horizontal pixel blender, directly downstream of the 7800 video mux (palette/RGB stage).
- Emulates composite-video smearing of alternating-luma 320-mode pixels.
- Consumes the mux's registered RGB, syncs, blanks and pix_ce, and produces the same signal set, one clock later, toward the MiSTer video output path.
- Blend mode comes from OSD, is latched per line, and is applied with a 3-pixel history window that restarts at each line.

Parameters:
- COLOR_W, 8, bits per RGB channel.
- BLANK_BLACK, 1, when 1 force RGB to 0 while hblank or vblank is high on output.

Ports:
- clk_sys  in  1  system clock, same domain as video mux.
- reset  in  1  asynchronous, active-high reset.
- blend_mode  in  2  OSD select: 0 off, 1 50/50, 2 adaptive 50/50, 3 75/25.
- in_red  in  COLOR_W  red from mux.
- in_green  in  COLOR_W  green from mux.
- in_blue  in  COLOR_W  blue from mux.
- in_hsync  in  1  hsync from mux.
- in_vsync  in  1  vsync from mux.
- in_hblank  in  1  hblank from mux.
- in_vblank  in  1  vblank from mux.
- in_pix_ce  in  1  pixel strobe from mux, 1 clk wide.
- red  out  COLOR_W  blended red.
- green  out  COLOR_W  blended green.
- blue  out  COLOR_W  blended blue.
- hsync  out  1  delayed hsync.
- vsync  out  1  delayed vsync.
- hblank  out  1  delayed hblank.
- vblank  out  1  delayed vblank.
- pix_ce  out  1  delayed pixel strobe.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high (port reset, clock clk_sys).
  - On assert, all outputs go to 0.
  - History taps h1 and h2 clear to 0; valid count clears to 0; latched mode clears to 0.
  - Reset mid-line: the next line starts clean, with no stale history.
- Pipeline: pix_ce equals in_pix_ce delayed by exactly 1 clk.
  - On the clk after in_pix_ce, RGB, syncs and blanks reflect input pixel I_k.
  - Outputs hold between strobes. Nothing updates when in_pix_ce is 0.
- History: on in_pix_ce, h2<=h1, h1<=I_k (24-bit RGB).
  - vcnt saturates at 2, incrementing by 1 per active pixel.
- Line restart: on in_pix_ce with in_hblank=1:
  - vcnt<=0; h1 and h2 are not loaded.
  - mode_l<=blend_mode. This is the only point mode changes, so there is no mid-line tearing.
- Mix function mix(a,b,w) is per channel, unsigned, with a (COLOR_W+2)-bit intermediate and truncating shift:
  - w=half: (a+b)>>1.
  - w=3q: (3a+b)>>2.
  - Result never overflows COLOR_W (max 255 with 255 inputs).
- Output selection for active pixel I_k, where vcnt is sampled before the update:
  - mode_l 0, or vcnt==0: I_k.
  - mode_l 1 and vcnt>=1: mix(I_k,h1,half).
  - mode_l 3 and vcnt>=1: mix(I_k,h1,3q).
  - mode_l 2 and vcnt==2:
    - If I_k==h2 and I_k!=h1, output mix(I_k,h1,half). This is the A-B-A alternation case.
    - Otherwise output I_k.
  - mode_l 2 and vcnt<2: I_k.
- Blanking: when BLANK_BLACK=1 and (in_hblank or in_vblank) at the strobe, output RGB=0.
  - Syncs and blanks always pass through unmodified, with 1-strobe alignment to RGB.
- Simultaneous hblank and vblank: the line-restart rule applies, and RGB=0.
- blend_mode changing while hblank=0: ignored until the next hblank strobe.
- Combinational path is limited to the mix adders and a 24-bit compare. All outputs are registered.

Decomposition:
- Shared package video_pkg:
  - blend_mode_t enum {BLEND_OFF, BLEND_HALF, BLEND_ADAPT, BLEND_3Q}.
  - rgb_t struct {r,g,b}.
  - RGB_BLACK constant.
- Sub-module rgb_mix:
  - Purely combinational.
  - Inputs: two rgb_t values and a weight select (half/3q).
  - Output: one rgb_t.
  - Instantiated once; its weight input is driven from mode_l.

Test Plan:
- Reset: assert reset mid-line with in_pix_ce toggling -> all outputs 0 immediately. After release, the first active pixel 0x102030 with mode 1 outputs 0x102030, since vcnt=0.
- Latency: mode 0, single in_pix_ce pulse with RGB 0xAABBCC and hsync=1 -> pix_ce=1 exactly 1 clk later with red=AA, green=BB, blue=CC, hsync=1, held until the next strobe.
- 50/50: mode 1; hblank strobe, then pixels 0xFF0000 and 0x0000FF -> outputs 0xFF0000, then 0x7F007F.
- 75/25: mode 3; pixels 0x000000 and 0xFFFFFF -> second output is 0xBFBFBF ((765+0)>>2=191).
- Adaptive: mode 2; pixels A=0x808080, B=0x202020, A, A -> outputs 808080, 202020, 505050, 808080 (the fourth fails A!=h1).
- Mode latch: switch blend_mode 0->1 mid-line -> the line stays unblended. After the next hblank strobe, the second pixel of the following line is blended.

Source files
------------

// File: rtl/video_pkg.sv
// Shared types for the post-palette video blender: blend mode select and 24-bit RGB pixel.
package video_pkg;

    localparam int PIX_W = 8;

    typedef enum logic [1:0] {
        BLEND_OFF   = 2'd0,
        BLEND_HALF  = 2'd1,
        BLEND_ADAPT = 2'd2,
        BLEND_3Q    = 2'd3
    } blend_mode_t;

    typedef struct packed {
        logic [PIX_W-1:0] r;
        logic [PIX_W-1:0] g;
        logic [PIX_W-1:0] b;
    } rgb_t;

    localparam rgb_t RGB_BLACK = '0;

endpackage

// File: rtl/video_blend_if.sv
// Pixel bus between the 7800 video mux and the blender, plus the blended output bus.
interface video_blend_if #(
    parameter int COLOR_W = 8
);
    logic [1:0]         blend_mode;
    logic [COLOR_W-1:0] in_red;
    logic [COLOR_W-1:0] in_green;
    logic [COLOR_W-1:0] in_blue;
    logic               in_hsync;
    logic               in_vsync;
    logic               in_hblank;
    logic               in_vblank;
    logic               in_pix_ce;
    logic [COLOR_W-1:0] red;
    logic [COLOR_W-1:0] green;
    logic [COLOR_W-1:0] blue;
    logic               hsync;
    logic               vsync;
    logic               hblank;
    logic               vblank;
    logic               pix_ce;

    modport master (
        output blend_mode, in_red, in_green, in_blue,
               in_hsync, in_vsync, in_hblank, in_vblank, in_pix_ce,
        input  red, green, blue, hsync, vsync, hblank, vblank, pix_ce
    );

    modport slave (
        input  blend_mode, in_red, in_green, in_blue,
               in_hsync, in_vsync, in_hblank, in_vblank, in_pix_ce,
        output red, green, blue, hsync, vsync, hblank, vblank, pix_ce
    );
endinterface

// File: rtl/video_blend_rgb_mix.sv
// Per-channel weighted average of two pixels: (a+b)>>1 or (3a+b)>>2, truncating.
module rgb_mix
    import video_pkg::*;
(
    input  rgb_t a,
    input  rgb_t b,
    input  logic sel_3q,
    output rgb_t y
);

    function automatic logic [PIX_W-1:0] mix_ch(
        input logic [PIX_W-1:0] ca,
        input logic [PIX_W-1:0] cb,
        input logic             q3
    );
        logic [PIX_W+1:0] sum;
        sum = {2'b00, ca} + {2'b00, cb};
        if (q3) begin
            // 3a+b peaks at 4*max, so two guard bits are enough
            sum = sum + {1'b0, ca, 1'b0};
            return sum[PIX_W+1:2];
        end
        return sum[PIX_W:1];
    endfunction

    assign y.r = mix_ch(a.r, b.r, sel_3q);
    assign y.g = mix_ch(a.g, b.g, sel_3q);
    assign y.b = mix_ch(a.b, b.b, sel_3q);

endmodule

// File: rtl/video_blend.sv
// Horizontal composite-smear blender: mixes each pixel with its left neighbour(s)
// according to a per-line latched OSD mode; all outputs are one clock behind the mux.
module video_blend
    import video_pkg::*;
#(
    parameter int COLOR_W     = PIX_W,
    parameter bit BLANK_BLACK = 1'b1
) (
    input  logic          clk_sys,
    input  logic          reset,
    video_blend_if.slave  vif
);

    rgb_t        cur, h1, h2, mixed, blended, out_rgb, rgb_q;
    logic [1:0]  vcnt;
    blend_mode_t mode_l;
    logic        blank;
    logic        hsync_q, vsync_q, hblank_q, vblank_q, pix_ce_q;

    assign cur = {vif.in_red, vif.in_green, vif.in_blue};

    rgb_mix u_mix (
        .a      (cur),
        .b      (h1),
        .sel_3q (mode_l == BLEND_3Q),
        .y      (mixed)
    );

    always_comb begin
        blended = cur;
        case (mode_l)
            BLEND_HALF, BLEND_3Q: if (vcnt != 2'd0) blended = mixed;
            // only smear a true A-B-A alternation, leaving flat runs and edges sharp
            BLEND_ADAPT: if (vcnt == 2'd2 && cur == h2 && cur != h1) blended = mixed;
            default: blended = cur;
        endcase
    end

    assign blank   = BLANK_BLACK && (vif.in_hblank || vif.in_vblank);
    assign out_rgb = blank ? RGB_BLACK : blended;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            rgb_q    <= RGB_BLACK;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            hblank_q <= 1'b0;
            vblank_q <= 1'b0;
            pix_ce_q <= 1'b0;
            h1       <= RGB_BLACK;
            h2       <= RGB_BLACK;
            vcnt     <= 2'd0;
            mode_l   <= BLEND_OFF;
        end else begin
            pix_ce_q <= vif.in_pix_ce;
            if (vif.in_pix_ce) begin
                rgb_q    <= out_rgb;
                hsync_q  <= vif.in_hsync;
                vsync_q  <= vif.in_vsync;
                hblank_q <= vif.in_hblank;
                vblank_q <= vif.in_vblank;
                if (vif.in_hblank) begin
                    // line restart: the only place the mode may change
                    vcnt   <= 2'd0;
                    mode_l <= blend_mode_t'(vif.blend_mode);
                end else begin
                    h2 <= h1;
                    h1 <= cur;
                    if (vcnt != 2'd2) vcnt <= vcnt + 2'd1;
                end
            end
        end
    end

    assign vif.red    = rgb_q.r;
    assign vif.green  = rgb_q.g;
    assign vif.blue   = rgb_q.b;
    assign vif.hsync  = hsync_q;
    assign vif.vsync  = vsync_q;
    assign vif.hblank = hblank_q;
    assign vif.vblank = vblank_q;
    assign vif.pix_ce = pix_ce_q;

endmodule

// File: tb/tb_video_blend.sv
// Directed bench for video_blend: hand-computed pixels for each blend mode, reset, latency and blanking.
module tb_video_blend;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    video_blend_if #(.COLOR_W(8)) vif ();

    video_blend #(.COLOR_W(8), .BLANK_BLACK(1'b1)) dut (
        .clk_sys (clk),
        .reset   (rst),
        .vif     (vif)
    );

    function automatic logic [23:0] out_rgb();
        return {vif.red, vif.green, vif.blue};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // one pixel strobe; returns at the negedge where the registered result is visible
    task automatic drive(input logic [23:0] rgb, input logic hs, input logic vs,
                         input logic hb, input logic vb);
        @(negedge clk);
        {vif.in_red, vif.in_green, vif.in_blue} = rgb;
        vif.in_hsync  = hs;
        vif.in_vsync  = vs;
        vif.in_hblank = hb;
        vif.in_vblank = vb;
        vif.in_pix_ce = 1'b1;
        @(negedge clk);
        vif.in_pix_ce = 1'b0;
    endtask

    task automatic pix(input logic [23:0] rgb);
        drive(rgb, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic new_line(input logic [1:0] mode);
        vif.blend_mode = mode;
        drive(24'h123456, 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        vif.blend_mode = 2'd0;
        {vif.in_red, vif.in_green, vif.in_blue} = 24'h0;
        vif.in_hsync = 1'b0; vif.in_vsync = 1'b0;
        vif.in_hblank = 1'b0; vif.in_vblank = 1'b0; vif.in_pix_ce = 1'b0;
        #1;
        chk("reset_rgb", {8'h0, out_rgb()}, 32'h0);
        chk("reset_ce", {31'h0, vif.pix_ce}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // latency, mode 0
        new_line(2'd0);
        chk("hblank_rgb_black", {8'h0, out_rgb()}, 32'h0);
        chk("hblank_pass", {31'h0, vif.hblank}, 32'h1);
        drive(24'hAABBCC, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("lat_ce", {31'h0, vif.pix_ce}, 32'h1);
        chk("lat_rgb", {8'h0, out_rgb()}, 32'h00AABBCC);
        chk("lat_hsync", {31'h0, vif.hsync}, 32'h1);
        chk("lat_hblank", {31'h0, vif.hblank}, 32'h0);
        @(negedge clk);
        chk("hold_ce", {31'h0, vif.pix_ce}, 32'h0);
        chk("hold_rgb", {8'h0, out_rgb()}, 32'h00AABBCC);
        chk("hold_hsync", {31'h0, vif.hsync}, 32'h1);

        // asynchronous reset mid-line with strobes toggling
        vif.in_pix_ce = 1'b1;
        {vif.in_red, vif.in_green, vif.in_blue} = 24'h111111;
        #2 rst = 1'b1;
        #1;
        chk("midrst_rgb", {8'h0, out_rgb()}, 32'h0);
        chk("midrst_hsync", {31'h0, vif.hsync}, 32'h0);
        chk("midrst_ce", {31'h0, vif.pix_ce}, 32'h0);
        @(negedge clk); vif.in_pix_ce = 1'b0;
        @(negedge clk); vif.in_pix_ce = 1'b1;
        @(negedge clk); vif.in_pix_ce = 1'b0; rst = 1'b0;

        new_line(2'd1);
        pix(24'h102030);
        chk("post_rst_first", {8'h0, out_rgb()}, 32'h00102030);
        pix(24'h304050);
        chk("post_rst_blend", {8'h0, out_rgb()}, 32'h00203040);

        // 50/50
        new_line(2'd1);
        pix(24'hFF0000);
        chk("half_p0", {8'h0, out_rgb()}, 32'h00FF0000);
        pix(24'h0000FF);
        chk("half_p1", {8'h0, out_rgb()}, 32'h007F007F);

        // 75/25
        new_line(2'd3);
        pix(24'h000000);
        chk("q3_p0", {8'h0, out_rgb()}, 32'h0);
        pix(24'hFFFFFF);
        chk("q3_p1", {8'h0, out_rgb()}, 32'h00BFBFBF);
        pix(24'hFFFFFF);
        chk("q3_max", {8'h0, out_rgb()}, 32'h00FFFFFF);

        // adaptive A-B-A
        new_line(2'd2);
        pix(24'h808080);
        chk("adapt_p0", {8'h0, out_rgb()}, 32'h00808080);
        pix(24'h202020);
        chk("adapt_p1", {8'h0, out_rgb()}, 32'h00202020);
        pix(24'h808080);
        chk("adapt_aba", {8'h0, out_rgb()}, 32'h00505050);
        pix(24'h808080);
        chk("adapt_flat", {8'h0, out_rgb()}, 32'h00808080);

        // mode only changes at hblank
        new_line(2'd0);
        pix(24'h112233);
        vif.blend_mode = 2'd1;
        pix(24'h334455);
        chk("latch_hold", {8'h0, out_rgb()}, 32'h00334455);
        new_line(2'd1);
        pix(24'h000000);
        chk("latch_p0", {8'h0, out_rgb()}, 32'h0);
        pix(24'h020406);
        chk("latch_p1", {8'h0, out_rgb()}, 32'h00010203);

        // vblank-only and hblank+vblank blanking
        drive(24'hFFFFFF, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("vblank_rgb", {8'h0, out_rgb()}, 32'h0);
        chk("vblank_pass", {31'h0, vif.vblank}, 32'h1);
        chk("vsync_pass", {31'h0, vif.vsync}, 32'h1);
        drive(24'hFFFFFF, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("hvblank_rgb", {8'h0, out_rgb()}, 32'h0);
        chk("hvblank_hb", {31'h0, vif.hblank}, 32'h1);
        pix(24'h446688);
        chk("after_hv_first", {8'h0, out_rgb()}, 32'h00446688);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
